// File: rtl/vmem_fill_engine_if.sv
// Write-side bus of the video memory fill engine: fill commands, single CPU
// writes, and the registered memory write port with status pulses.
interface vmem_fill_engine_if #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6,
  parameter int PIX_W    = 15
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [COL_BITS-1:0]          cmd_x;
  logic [ROW_BITS-1:0]          cmd_y;
  logic [COL_BITS:0]            cmd_w;
  logic [ROW_BITS:0]            cmd_h;
  logic [PIX_W-1:0]             cmd_color;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [ROW_BITS+COL_BITS-1:0] wr_addr;
  logic [PIX_W-1:0]             wr_data;
  logic [31:0]                  mem_waddr;
  logic [31:0]                  mem_wdata;
  logic                         mem_web;
  logic                         busy;
  logic                         done;
  logic                         err;

  // Engine side: masters the memory write port.
  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  wr_valid, wr_addr, wr_data,
    output cmd_ready, wr_ready,
    output mem_waddr, mem_wdata, mem_web, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output wr_valid, wr_addr, wr_data,
    input  cmd_ready, wr_ready,
    input  mem_waddr, mem_wdata, mem_web, busy, done, err
  );
endinterface

// File: rtl/vmem_fill_engine.sv
// Rectangle-fill / single-write engine driving the video memory write port,
// one registered write per clock in row-major order.
module vmem_fill_engine #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6,
  parameter int PIX_W    = 15
) (
  input logic              clkb,
  input logic              rst_n,
  vmem_fill_engine_if.master bus
);

  localparam int AW = COL_BITS + ROW_BITS;
  localparam int CW = ((COL_BITS > ROW_BITS) ? COL_BITS : ROW_BITS) + 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] x0_q, x0_d, xend_q, xend_d, col_q, col_d;
  logic [ROW_BITS-1:0] yend_q, yend_d, row_q, row_d;
  logic [PIX_W-1:0]    color_q, color_d;
  logic [AW-1:0]       waddr_p1, waddr_d;
  logic [PIX_W-1:0]    wdata_p1, wdata_d;
  logic                vld_p1, vld_d;
  logic                done_q, done_d, err_q, err_d;
  logic [CW-1:0]       x_sum, y_sum;
  logic                cmd_ok, last_col, last_cell;

  // Bounds are checked with headroom so x+w and y+h cannot wrap.
  assign x_sum  = CW'(bus.cmd_x) + CW'(bus.cmd_w);
  assign y_sum  = CW'(bus.cmd_y) + CW'(bus.cmd_h);
  assign cmd_ok = (bus.cmd_w != '0) && (bus.cmd_h != '0) &&
                  (x_sum <= CW'(1 << COL_BITS)) && (y_sum <= CW'(1 << ROW_BITS));

  assign last_col  = (col_q == xend_q);
  assign last_cell = last_col && (row_q == yend_q);

  always_comb begin
    state_d       = state_q;
    x0_d          = x0_q;
    xend_d        = xend_q;
    yend_d        = yend_q;
    col_d         = col_q;
    row_d         = row_q;
    color_d       = color_q;
    waddr_d       = waddr_p1;
    wdata_d       = wdata_p1;
    vld_d         = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.wr_ready  = !bus.cmd_valid;
        if (bus.cmd_valid) begin
          if (cmd_ok) begin
            // End coordinates use modular width, so a full-span w/h (MSB set,
            // low bits zero, start 0) still yields the last column/row.
            state_d = FILL;
            x0_d    = bus.cmd_x;
            xend_d  = bus.cmd_x + bus.cmd_w[COL_BITS-1:0] - COL_BITS'(1);
            yend_d  = bus.cmd_y + bus.cmd_h[ROW_BITS-1:0] - ROW_BITS'(1);
            col_d   = bus.cmd_x;
            row_d   = bus.cmd_y;
            color_d = bus.cmd_color;
            vld_d   = 1'b1;
            waddr_d = {bus.cmd_y, bus.cmd_x};
            wdata_d = bus.cmd_color;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.wr_valid) begin
          vld_d   = 1'b1;
          waddr_d = bus.wr_addr;
          wdata_d = bus.wr_data;
        end
      end
      FILL: begin
        bus.busy = 1'b1;
        if (last_cell) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (last_col) begin
            col_d = x0_q;
            row_d = row_q + ROW_BITS'(1);
          end else begin
            col_d = col_q + COL_BITS'(1);
          end
          vld_d   = 1'b1;
          waddr_d = {row_d, col_d};
          wdata_d = color_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      x0_q     <= '0;
      xend_q   <= '0;
      yend_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      color_q  <= '0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      vld_p1   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      x0_q     <= x0_d;
      xend_q   <= xend_d;
      yend_q   <= yend_d;
      col_q    <= col_d;
      row_q    <= row_d;
      color_q  <= color_d;
      waddr_p1 <= waddr_d;
      wdata_p1 <= wdata_d;
      vld_p1   <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Stage p1: registered memory write port.
  assign bus.mem_waddr = 32'(waddr_p1);
  assign bus.mem_wdata = 32'(wdata_p1);
  assign bus.mem_web   = vld_p1;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Randomized and directed bench for vmem_fill_engine against a cell-list
// reference model of fills and single writes.
module tb_vmem_fill_engine;

  logic clkb;
  logic rst_n;

  vmem_fill_engine_if bus ();

  vmem_fill_engine dut (
    .clkb (clkb),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clkb = 1'b0;
  always #5 clkb = ~clkb;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [12:0] fill_q[$];
  logic [14:0] fill_color;
  bit          in_fill;
  logic [12:0] last_addr;
  logic [14:0] last_data;
  bit          wr_acc;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] obs_vec();
    return 96'({bus.mem_web, bus.mem_waddr, bus.mem_wdata, bus.busy, bus.done, bus.err});
  endfunction

  task automatic model_reset();
    fill_q.delete();
    in_fill   = 0;
    last_addr = '0;
    last_data = '0;
    fill_color = '0;
  endtask

  // One clock of stimulus: inputs are already driven; check handshake outputs,
  // advance the model, then check the registered outputs after the edge.
  task automatic cycle();
    bit e_web, e_done, e_err, e_busy;
    int x, y, w, h;
    #1;
    chk("cmd_ready", 96'(bus.cmd_ready), 96'(!in_fill));
    chk("wr_ready", 96'(bus.wr_ready), 96'(!in_fill && !bus.cmd_valid));
    e_web = 0; e_done = 0; e_err = 0;
    wr_acc = 0;
    if (!in_fill) begin
      if (bus.cmd_valid) begin
        x = int'(bus.cmd_x); y = int'(bus.cmd_y);
        w = int'(bus.cmd_w); h = int'(bus.cmd_h);
        if (w != 0 && h != 0 && x + w <= 128 && y + h <= 64) begin
          for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
              fill_q.push_back({6'(y + r), 7'(x + c)});
          fill_color = bus.cmd_color;
        end else begin
          e_err = 1;
        end
      end else if (bus.wr_valid) begin
        e_web = 1;
        last_addr = bus.wr_addr;
        last_data = bus.wr_data;
        wr_acc = 1;
      end
    end
    if (in_fill && fill_q.size() == 0) begin
      e_done = 1;
      in_fill = 0;
    end else if (fill_q.size() != 0) begin
      e_web = 1;
      last_addr = fill_q.pop_front();
      last_data = fill_color;
      in_fill = 1;
    end
    e_busy = in_fill;
    @(posedge clkb);
    #1;
    chk("mem_out", obs_vec(),
        96'({e_web, 32'(last_addr), 32'(last_data), e_busy, e_done, e_err}));
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0;
    bus.cmd_h = '0; bus.cmd_color = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h, input int color);
    bus.cmd_valid = 1;
    bus.cmd_x = 7'(x); bus.cmd_y = 6'(y); bus.cmd_w = 8'(w); bus.cmd_h = 7'(h);
    bus.cmd_color = 15'(color);
    cycle();
    bus.cmd_valid = 0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    idle_inputs();
    rst_n = 0;
    model_reset();
    #23;
    chk("reset_out", obs_vec(), 96'(0));
    chk("reset_cmd_ready", 96'(bus.cmd_ready), 96'(1));
    #5 rst_n = 1;
    @(posedge clkb); #1;

    // Directed 4x2 fill; busy must be high for exactly 8 cycles.
    send_cmd(2, 3, 4, 2, 'h7C00);
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (bus.busy === 1'b1) busy_cnt++;
    end
    chk("busy_cycles", 96'(busy_cnt), 96'(8));
    run_idle(2);

    // Illegal commands
    send_cmd(120, 0, 9, 1, 'h1111);
    cycle();
    send_cmd(0, 0, 4, 0, 'h2222);
    cycle();
    send_cmd(0, 60, 1, 5, 'h3333);
    run_idle(2);

    // Command and single write together: command wins, write waits for done.
    bus.wr_valid = 1; bus.wr_addr = 13'h0ABC; bus.wr_data = 15'h1234;
    send_cmd(10, 5, 3, 2, 'h03E0);
    wr_acc = 0;
    for (int i = 0; i < 20 && !wr_acc; i++) cycle();
    chk("pending_wr_accepted", 96'(wr_acc), 96'(1));
    bus.wr_valid = 0;
    run_idle(2);

    // Back-to-back single writes
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1;
      bus.wr_addr = 13'($urandom);
      bus.wr_data = 15'($urandom);
      cycle();
    end
    bus.wr_valid = 0;
    run_idle(2);

    // Degenerate 1x1 and full-screen fills
    send_cmd(127, 63, 1, 1, 'h5555);
    run_idle(3);
    send_cmd(0, 0, 128, 64, 'h001F);
    for (int i = 0; i < 8200 && in_fill; i++) cycle();
    chk("full_fill_finished", 96'(in_fill), 96'(0));
    run_idle(2);

    // Randomized traffic; inputs keep changing during fills.
    for (int i = 0; i < 1500; i++) begin
      bus.cmd_valid = ($urandom_range(0, 7) == 0);
      bus.cmd_x = 7'($urandom_range(0, 127));
      bus.cmd_y = 6'($urandom_range(0, 63));
      bus.cmd_w = ($urandom_range(0, 15) == 0) ? 8'd128 : 8'($urandom_range(0, 20));
      bus.cmd_h = 7'($urandom_range(0, 12));
      bus.cmd_color = 15'($urandom);
      bus.wr_valid = $urandom_range(0, 1);
      bus.wr_addr = 13'($urandom);
      bus.wr_data = 15'($urandom);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 2000 && in_fill; i++) cycle();
    run_idle(2);

    // Reset during the 3rd write of a 16-cell fill
    send_cmd(0, 0, 4, 4, 'h7FFF);
    cycle();
    cycle();
    rst_n = 0;
    #1;
    chk("async_reset_out", obs_vec(), 96'(0));
    chk("async_reset_cmd_ready", 96'(bus.cmd_ready), 96'(1));
    model_reset();
    #3 rst_n = 1;
    run_idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
